uart_tx_framer: RTL and testbench
=================================

# uart_tx_framer

Parametrised UART transmit framer: accepts a data word over a valid/ready handshake and serialises it as start bit, DATA_W data bits LSB first, an optional parity bit, and one or two stop bits. It generalises the existing single-width even-parity register. Parity mode and stop-bit count are selectable at run time, and bit timing is generated internally. It sits between the TX FIFO/host interface and the `tx` pad.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9; any other value is an elaboration error.
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 2.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_W  word to send; sampled on handshake.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  framer idle and able to accept; high iff state == IDLE.
- parity_mode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space; 5..7 are treated as none. Sampled on handshake.
- two_stop  in  1  0: one stop bit; 1: two stop bits. Sampled on handshake.
- tx  out  1  serial line, registered, idle high.
- busy  out  1  frame in progress; equals ~tx_ready.
- parity_bit  out  1  parity value of the most recently accepted frame, registered at handshake; 0 when mode is none.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx = 1. On tx_valid && tx_ready:
  - latch tx_data, parity_mode and two_stop into shadow registers;
  - compute parity_bit;
  - go to START, tx <= 0.
- START: hold for CLKS_PER_BIT cycles, then go to DATA with tx <= shadow[0].
- DATA: each bit is held CLKS_PER_BIT cycles, bit index 0..DATA_W-1.
  - After the last bit, go to PARITY if mode is not none, else go to STOP.
- PARITY: tx = parity_bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx = 1 for CLKS_PER_BIT cycles (2*CLKS_PER_BIT if two_stop), then go to IDLE.
- Parity values:
  - even = ^data (total ones including parity is even);
  - odd = ~^data;
  - mark = 1;
  - space = 0.
- Counter widths:
  - bit-timer: $clog2(CLKS_PER_BIT) bits, counts CLKS_PER_BIT-1 down to 0;
  - bit index: $clog2(DATA_W) bits;
  - stop count: 1 bit.
- Input changes after the handshake (data, parity_mode, two_stop) do not affect the frame in flight.
- tx_valid while busy is ignored; there is no buffering and no error.
- Reset at any time (including mid-frame) immediately forces:
  - state IDLE, tx = 1, tx_ready = 1, busy = 0, parity_bit = 0;
  - all counters and shadow registers cleared.
  - The partial frame is abandoned.

## Timing
- Reset values: tx 1, tx_ready 1, busy 0, parity_bit 0.
- Handshake at edge k: tx is low from the cycle after edge k (latency 1). tx_ready and busy change at the same edge.
- Frame length on tx = CLKS_PER_BIT × (1 + DATA_W + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- The STOP → IDLE transition occurs at the end of the last stop-bit cycle. tx_ready is high for at least one cycle before the next handshake.
- Minimum idle high between back-to-back frames is one extra clk (stop effectively +1 cycle). With tx_valid held high, frames repeat with exactly that 1-cycle gap.
- No combinational path from any input to tx.

## Structure
- Package uart_pkg:
  - parity-mode localparams PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2, PAR_MARK=3, PAR_SPACE=4;
  - tx state enum.
- Sub-module uart_parity_gen (combinational, parameter DATA_W):
  - inputs: data, mode;
  - output: parity value (0 for none / invalid modes);
  - instantiated once, registered into parity_bit at handshake.

## Test plan
Tests use CLKS_PER_BIT=4 and DATA_W=8 unless noted.
- 0xA5, even, one stop -> tx: 0, then 1,0,1,0,0,1,0,1, then parity 0, then 1. 44 cycles total; parity_bit=0; tx_ready returns at cycle 44.
- 0xA5, odd, two stop -> parity bit 1, 48-cycle frame, parity_bit=1.
- 0x07, mode none, two stop -> no parity slot, 44 cycles. Also send 0x07 with mode 6 -> frame identical to mode none.
- Mark then space with 0x00 -> parity slot 1, then 0. Change parity_mode mid-frame -> no effect on the current frame.
- tx_valid held high with 0x3C then 0xC3 -> two complete frames with exactly one idle-high cycle between them; tx_ready high for exactly one cycle.
- Reset asserted during data bit 3 -> tx=1 and tx_ready=1 in the same cycle. After release, 0x55 sends a clean, full frame.
- DATA_W=5, 0x1F, even -> 5 data ones then parity 1, frame length 32 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity-mode codes and transmit state encoding for the UART framer
package uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Codes 5..7 fall outside the legal range and behave exactly like PAR_NONE.
  function automatic logic parity_enabled(input logic [2:0] mode);
    return (mode >= PAR_EVEN) && (mode <= PAR_SPACE);
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// rtl/uart_parity_gen.sv - combinational parity value for a data word under the selected mode
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        mode,
  output logic              parity
);

  always_comb begin
    parity = 1'b0;
    case (mode)
      PAR_EVEN: parity = ^data;
      PAR_ODD:  parity = ~^data;
      PAR_MARK: parity = 1'b1;
      default:  parity = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start, DATA_W data bits LSB first, optional parity, 1 or 2 stops
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [2:0]        parity_mode,
  input  logic              two_stop,
  output logic              tx,
  output logic              busy,
  output logic              parity_bit
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W   = $clog2(DATA_W);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DATA_W - 1);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_framer: DATA_W must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_framer: CLKS_PER_BIT must be >= 2");
  end

  tx_state_t           state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                stop_q, stop_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                tx_q, tx_d;
  logic [2:0]          mode_q;
  logic                two_stop_q;
  logic                parity_q;
  logic                parity_next;
  logic                accept;
  logic                timer_done;

  assign accept     = tx_valid && (state_q == ST_IDLE);
  assign timer_done = (timer_q == '0);

  uart_parity_gen #(.DATA_W(DATA_W)) u_parity (
    .data   (tx_data),
    .mode   (parity_mode),
    .parity (parity_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // data_q is a shift register: the next bit to send is always at bit 0.
  always_comb begin
    state_d = state_q;
    timer_d = timer_done ? timer_q : timer_q - 1'b1;
    idx_d   = idx_q;
    stop_d  = stop_q;
    data_d  = data_q;
    tx_d    = tx_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          state_d = ST_START;
          tx_d    = 1'b0;
          timer_d = TIMER_MAX;
          data_d  = tx_data;
          idx_d   = '0;
          stop_d  = 1'b0;
        end
      end
      ST_START: begin
        if (timer_done) begin
          state_d = ST_DATA;
          tx_d    = data_q[0];
          data_d  = data_q >> 1;
          timer_d = TIMER_MAX;
        end
      end
      ST_DATA: begin
        if (timer_done) begin
          timer_d = TIMER_MAX;
          if (idx_q == IDX_LAST) begin
            if (parity_enabled(mode_q)) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d  = idx_q + 1'b1;
            tx_d   = data_q[0];
            data_d = data_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (timer_done) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          timer_d = TIMER_MAX;
        end
      end
      ST_STOP: begin
        if (timer_done) begin
          if (two_stop_q && !stop_q) begin
            stop_d  = 1'b1;
            timer_d = TIMER_MAX;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q    <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      mode_q     <= PAR_NONE;
      two_stop_q <= 1'b0;
      parity_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      if (accept) begin
        mode_q     <= parity_mode;
        two_stop_q <= two_stop;
        parity_q   <= parity_next;
      end
    end
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign busy       = ~tx_ready;
  assign tx         = tx_q;
  assign parity_bit = parity_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed self-checking bench for uart_tx_framer (DATA_W 8 and 5, CLKS_PER_BIT 4)
module tb_uart_tx_framer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] tx_data;
  logic [2:0] parity_mode;
  logic       two_stop;
  logic       tx_valid8, tx_valid5;
  logic       tx_ready8, tx8, busy8, par8;
  logic       tx_ready5, tx5, busy5, par5;

  int checks = 0;
  int errors = 0;

  logic trace_tx  [0:255];
  logic trace_rdy [0:255];

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data[7:0]),
    .tx_valid    (tx_valid8),
    .tx_ready    (tx_ready8),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx8),
    .busy        (busy8),
    .parity_bit  (par8)
  );

  uart_tx_framer #(.DATA_W(5), .CLKS_PER_BIT(CPB)) dut5 (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data[4:0]),
    .tx_valid    (tx_valid5),
    .tx_ready    (tx_ready5),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx5),
    .busy        (busy5),
    .parity_bit  (par5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input int start, input int n, input bit sel5);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      trace_tx[start + i]  = sel5 ? tx5 : tx8;
      trace_rdy[start + i] = sel5 ? tx_ready5 : tx_ready8;
    end
  endtask

  // Handshake happens at the posedge inside this task; the next negedge is trace index 0.
  // Inputs are scrambled right after the handshake so a frame that re-reads them is caught.
  task automatic send(input logic [8:0] d, input logic [2:0] m, input logic ts, input bit sel5);
    @(negedge clk);
    tx_data     = d;
    parity_mode = m;
    two_stop    = ts;
    if (sel5) tx_valid5 = 1'b1;
    else      tx_valid8 = 1'b1;
    @(posedge clk);
    #1;
    tx_valid8   = 1'b0;
    tx_valid5   = 1'b0;
    tx_data     = ~d;
    parity_mode = m ^ 3'd3;
    two_stop    = ~ts;
  endtask

  function automatic int busy_len(input int start);
    int i;
    i = start;
    while (i < 256 && !trace_rdy[i]) i++;
    return i - start;
  endfunction

  function automatic logic [15:0] slots(input int start, input int n, input int off);
    logic [15:0] s;
    s = '1;
    for (int i = 0; i < n; i++) s[i] = trace_tx[start + CPB * i + off];
    return s;
  endfunction

  function automatic logic [15:0] exp_frame(input logic [8:0] d, input int nb, input bit pen, input logic p);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < nb; i++) f[1 + i] = d[i];
    if (pen) f[1 + nb] = p;
    return f;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      trace_tx[i]  = 1'b1;
      trace_rdy[i] = 1'b1;
    end
    reset       = 1'b1;
    tx_data     = '0;
    parity_mode = 3'd0;
    two_stop    = 1'b0;
    tx_valid8   = 1'b0;
    tx_valid5   = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_tx", tx8, 1'b1);
    check("reset_ready", tx_ready8, 1'b1);
    check("reset_busy", busy8, 1'b0);
    check("reset_parity", par8, 1'b0);
    reset = 1'b0;

    // 0xA5 even, one stop: 44 cycles, parity 0
    send(9'h0A5, 3'd1, 1'b0, 1'b0);
    capture(0, 50, 1'b0);
    check("a5_even_len", busy_len(0), 44);
    check("a5_even_slots_head", slots(0, 11, 0), exp_frame(9'h0A5, 8, 1'b1, 1'b0));
    check("a5_even_slots_tail", slots(0, 11, 3), exp_frame(9'h0A5, 8, 1'b1, 1'b0));
    check("a5_even_parity_bit", par8, 1'b0);
    check("a5_even_idle_tx", trace_tx[44], 1'b1);

    // 0xA5 odd, two stop: 48 cycles, parity 1
    send(9'h0A5, 3'd2, 1'b1, 1'b0);
    capture(0, 52, 1'b0);
    check("a5_odd_len", busy_len(0), 48);
    check("a5_odd_slots", slots(0, 12, 1), exp_frame(9'h0A5, 8, 1'b1, 1'b1));
    check("a5_odd_parity_bit", par8, 1'b1);

    // 0x07 none, two stop: no parity slot, 44 cycles
    send(9'h007, 3'd0, 1'b1, 1'b0);
    capture(0, 50, 1'b0);
    check("07_none_len", busy_len(0), 44);
    check("07_none_slots", slots(0, 11, 2), exp_frame(9'h007, 8, 1'b0, 1'b0));
    check("07_none_parity_bit", par8, 1'b0);

    // 0x07 mode 6 behaves as none
    send(9'h007, 3'd6, 1'b1, 1'b0);
    capture(0, 50, 1'b0);
    check("07_mode6_len", busy_len(0), 44);
    check("07_mode6_slots", slots(0, 11, 1), exp_frame(9'h007, 8, 1'b0, 1'b0));
    check("07_mode6_parity_bit", par8, 1'b0);

    // 0x00 mark then space; mode flips mid-frame inside send()
    send(9'h000, 3'd3, 1'b0, 1'b0);
    capture(0, 50, 1'b0);
    check("00_mark_len", busy_len(0), 44);
    check("00_mark_slots", slots(0, 11, 1), exp_frame(9'h000, 8, 1'b1, 1'b1));
    check("00_mark_parity_bit", par8, 1'b1);
    send(9'h000, 3'd4, 1'b0, 1'b0);
    capture(0, 50, 1'b0);
    check("00_space_len", busy_len(0), 44);
    check("00_space_slots", slots(0, 11, 1), exp_frame(9'h000, 8, 1'b1, 1'b0));
    check("00_space_parity_bit", par8, 1'b0);

    // Back-to-back with tx_valid held: 0x3C then 0xC3, one idle-high cycle between
    @(negedge clk);
    tx_data     = 9'h03C;
    parity_mode = 3'd1;
    two_stop    = 1'b0;
    tx_valid8   = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 9'h0C3;
    capture(0, 89, 1'b0);
    tx_valid8 = 1'b0;
    capture(89, 6, 1'b0);
    check("b2b_first_len", busy_len(0), 44);
    check("b2b_gap_ready", trace_rdy[44], 1'b1);
    check("b2b_gap_tx", trace_tx[44], 1'b1);
    check("b2b_second_start_ready", trace_rdy[45], 1'b0);
    check("b2b_second_start_tx", trace_tx[45], 1'b0);
    check("b2b_second_len", busy_len(45), 44);
    check("b2b_first_slots", slots(0, 11, 1), exp_frame(9'h03C, 8, 1'b1, 1'b0));
    check("b2b_second_slots", slots(45, 11, 1), exp_frame(9'h0C3, 8, 1'b1, 1'b0));
    check("b2b_no_third", trace_rdy[93], 1'b1);

    // Reset during data bit 3 (cycles 16..19) of a 0x00 mark frame
    send(9'h000, 3'd3, 1'b0, 1'b0);
    capture(0, 17, 1'b0);
    check("mid_reset_pre_tx", tx8, 1'b0);
    check("mid_reset_pre_parity", par8, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_reset_tx", tx8, 1'b1);
    check("mid_reset_ready", tx_ready8, 1'b1);
    check("mid_reset_busy", busy8, 1'b0);
    check("mid_reset_parity", par8, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    send(9'h055, 3'd1, 1'b0, 1'b0);
    capture(0, 50, 1'b0);
    check("post_reset_len", busy_len(0), 44);
    check("post_reset_slots", slots(0, 11, 1), exp_frame(9'h055, 8, 1'b1, 1'b0));

    // DATA_W=5: 0x1F even -> parity 1, 32 cycles
    send(9'h01F, 3'd1, 1'b0, 1'b1);
    capture(0, 40, 1'b1);
    check("w5_len", busy_len(0), 32);
    check("w5_slots", slots(0, 8, 1), exp_frame(9'h01F, 5, 1'b1, 1'b1));
    check("w5_parity_bit", par5, 1'b1);
    check("w5_other_idle", tx_ready8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
